twd_host: RTL and testbench

Two-wire debug (TWD) host engine: the initiator end of the DCK/DIO debug link that the chip exposes as a target. It accepts single register read/write requests on a valid/ready interface, serialises them onto DCK/DIO, and returns the target's acknowledgement, read data and parity status. It is used in the FPGA debug probe and in chip-level benches as a synthesizable stimulus source, and connects to bidirectional pad signals in the same out/oe/in style as the chip pads.

---
 rtl/twd_host_if.sv | 26 ++
 rtl/twd_host.sv | 179 +++++++++++++++++
 tb/tb_twd_host.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/twd_host_if.sv
// Request/response and DCK/DIO pad bundle for the two-wire debug host engine.
// slave is the host engine itself; master is the requester plus the pad/target side.
interface twd_host_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [6:0]  req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [1:0]  rsp_status;
   logic [31:0] rsp_rdata;
   logic        dck;
   logic        dio_out;
   logic        dio_oe;
   logic        dio_in;

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, dio_in,
      output req_ready, rsp_valid, rsp_status, rsp_rdata, dck, dio_out, dio_oe
   );

   modport master (
      output req_valid, req_write, req_addr, req_wdata, dio_in,
      input  req_ready, rsp_valid, rsp_status, rsp_rdata, dck, dio_out, dio_oe
   );
endinterface

// File: rtl/twd_host.sv
// Two-wire debug host: serialises one register read/write per request onto DCK/DIO,
// retries on WAIT, and reports ack status, read data and read parity.
module twd_host #(
   parameter int DIV       = 4,
   parameter int MAX_RETRY = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   twd_host_if.slave  bus
);
   localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
   localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

   typedef enum logic [3:0] {
      S_IDLE, S_START, S_HDR, S_HPAR, S_TURN1, S_ACK,
      S_RDATA, S_RPAR, S_TURN2, S_WDATA, S_WPAR, S_GAP
   } state_t;

   state_t          r_state;
   logic [5:0]      r_bit;
   logic [DW-1:0]   r_div;
   logic            r_dck;
   logic            r_oe;
   logic            r_out;
   logic [RW-1:0]   r_retry;
   logic [2:0]      r_ack;
   logic            r_par_err;
   logic            r_rsp_valid;
   logic [1:0]      r_rsp_status;
   logic [31:0]     r_rsp_rdata;
   logic            r_write;
   logic [6:0]      r_addr;
   logic [31:0]     r_wdata;
   logic [31:0]     r_rsh;

   state_t          w_state_nxt;
   logic [5:0]      w_bit_nxt;
   logic [RW-1:0]   w_retry_nxt;
   logic            w_done;
   logic [1:0]      w_status;
   logic            w_active;
   logic            w_half_end;
   logic            w_rise;
   logic            w_bit_end;
   logic            w_accept;
   logic [7:0]      w_hdr;
   logic            w_ack_ok;
   logic            w_ack_wait;

   // Pin values for the bit that is about to start: {oe, out}
   function automatic logic [1:0] f_pins(input state_t st, input logic [4:0] bidx,
                                         input logic [7:0] hdr, input logic [31:0] wd);
      logic [1:0] p;
      p = 2'b10;
      case (st)
         S_START:                                   p = 2'b11;
         S_HDR:                                     p = {1'b1, hdr[3'd7 - bidx[2:0]]};
         S_HPAR:                                    p = {1'b1, ^hdr};
         S_TURN1, S_ACK, S_RDATA, S_RPAR, S_TURN2:  p = 2'b00;
         S_WDATA:                                   p = {1'b1, wd[bidx]};
         S_WPAR:                                    p = {1'b1, ^wd};
         default:                                   p = 2'b10;
      endcase
      return p;
   endfunction

   function automatic logic [1:0] f_status(input logic [2:0] ack, input logic wr,
                                           input logic perr);
      if (ack == 3'b001)      return (!wr && perr) ? 2'd3 : 2'd0;
      else if (ack == 3'b010) return 2'd1;
      else                    return 2'd2;
   endfunction

   assign w_active   = (r_state != S_IDLE);
   assign w_half_end = (r_div == DIV_LAST);
   assign w_rise     = w_active && w_half_end && !r_dck;
   assign w_bit_end  = w_active && w_half_end && r_dck;
   assign w_accept   = bus.req_valid && (r_state == S_IDLE);
   assign w_hdr      = {~r_write, r_addr};
   assign w_ack_ok   = (r_ack == 3'b001);
   assign w_ack_wait = (r_ack == 3'b010);

   always_comb begin
      w_state_nxt = r_state;
      w_bit_nxt   = r_bit;
      w_retry_nxt = r_retry;
      w_done      = 1'b0;
      w_status    = 2'd0;
      if (r_state == S_IDLE) begin
         if (w_accept) begin
            w_state_nxt = S_START;
            w_bit_nxt   = '0;
            w_retry_nxt = '0;
         end
      end else if (w_bit_end) begin
         w_bit_nxt = '0;
         case (r_state)
            S_START: w_state_nxt = S_HDR;
            S_HDR:   if (r_bit == 6'd7) w_state_nxt = S_HPAR;
                     else w_bit_nxt = r_bit + 6'd1;
            S_HPAR:  w_state_nxt = S_TURN1;
            S_TURN1: w_state_nxt = S_ACK;
            S_ACK:   if (r_bit == 6'd2) w_state_nxt = (w_ack_ok && !r_write) ? S_RDATA : S_TURN2;
                     else w_bit_nxt = r_bit + 6'd1;
            S_RDATA: if (r_bit == 6'd31) w_state_nxt = S_RPAR;
                     else w_bit_nxt = r_bit + 6'd1;
            S_RPAR:  w_state_nxt = S_TURN2;
            S_TURN2: w_state_nxt = (w_ack_ok && r_write) ? S_WDATA : S_GAP;
            S_WDATA: if (r_bit == 6'd31) w_state_nxt = S_WPAR;
                     else w_bit_nxt = r_bit + 6'd1;
            S_WPAR:  w_state_nxt = S_GAP;
            S_GAP: begin
               // A WAIT with retries left re-sends the latched request silently
               if (w_ack_wait && (r_retry < RETRY_MAX)) begin
                  w_state_nxt = S_START;
                  w_retry_nxt = r_retry + RW'(1);
               end else begin
                  w_state_nxt = S_IDLE;
                  w_done      = 1'b1;
                  w_status    = f_status(r_ack, r_write, r_par_err);
               end
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_bit        <= '0;
         r_div        <= '0;
         r_dck        <= 1'b0;
         r_oe         <= 1'b1;
         r_out        <= 1'b0;
         r_retry      <= '0;
         r_ack        <= '0;
         r_par_err    <= 1'b0;
         r_rsp_valid  <= 1'b0;
         r_rsp_status <= '0;
         r_rsp_rdata  <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_bit       <= w_bit_nxt;
         r_retry     <= w_retry_nxt;
         {r_oe, r_out} <= f_pins(w_state_nxt, w_bit_nxt[4:0], w_hdr, r_wdata);
         if (!w_active || w_half_end) r_div <= '0;
         else                         r_div <= r_div + DW'(1);
         if (!w_active)       r_dck <= 1'b0;
         else if (w_half_end) r_dck <= ~r_dck;
         if (w_rise && r_state == S_ACK)  r_ack     <= {bus.dio_in, r_ack[2:1]};
         if (w_rise && r_state == S_RPAR) r_par_err <= (^r_rsh) ^ bus.dio_in;
         r_rsp_valid <= w_done;
         if (w_done) begin
            r_rsp_status <= w_status;
            if (!r_write && w_ack_ok) r_rsp_rdata <= r_rsh;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_write <= bus.req_write;
         r_addr  <= bus.req_addr;
         r_wdata <= bus.req_wdata;
      end
      if (w_rise && r_state == S_RDATA) r_rsh <= {bus.dio_in, r_rsh[31:1]};
   end

   assign bus.req_ready  = (r_state == S_IDLE);
   assign bus.rsp_valid  = r_rsp_valid;
   assign bus.rsp_status = r_rsp_status;
   assign bus.rsp_rdata  = r_rsp_rdata;
   assign bus.dck        = r_dck;
   assign bus.dio_out    = r_out;
   assign bus.dio_oe     = r_oe;
endmodule

// File: tb/tb_twd_host.sv
// Bench for twd_host: behavioural DIO target plus a response scoreboard.
module tb_twd_host;
   localparam int DIV = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   twd_host_if bus();

   twd_host #(.DIV(DIV), .MAX_RETRY(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  status;
      logic [31:0] rdata;
      int          lat;
      int          acc;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Target model configuration and observations
   bit          t_present = 1'b1;
   int          t_wait_n = 0;
   logic [31:0] t_rdata = '0;
   bit          t_flip = 1'b0;
   int          t_attempts = 0;
   int          t_starts = 0;
   int          oe_err = 0;
   logic [7:0]  t_hdr = '0;
   logic        t_hpar = 1'b0;
   logic [31:0] t_wcap = '0;
   logic        t_wpar = 1'b0;
   int          t_idx = 0;
   bit          t_in_frame = 1'b0;
   logic [2:0]  t_ack = '0;
   logic        t_rnw = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   function automatic logic exp_oe(input int i);
      if (i <= 9)  return 1'b1;
      if (i <= 13) return 1'b0;
      if (t_ack == 3'b001 && t_rnw) return (i == 48);
      return (i >= 15);
   endfunction

   initial begin : target
      bus.dio_in = 1'b0;
      forever begin
         @(bus.dck or rst_n);
         if (!rst_n) begin
            t_in_frame = 1'b0;
            t_idx      = 0;
            bus.dio_in = 1'b0;
         end else if (bus.dck === 1'b1) begin
            if (!t_in_frame) begin
               if (bus.dio_oe === 1'b1 && bus.dio_out === 1'b1) begin
                  t_in_frame = 1'b1;
                  t_idx      = 1;
                  t_starts++;
                  t_attempts++;
                  if (!t_present)                t_ack = 3'b000;
                  else if (t_attempts <= t_wait_n) t_ack = 3'b010;
                  else                           t_ack = 3'b001;
               end
            end else begin
               if (bus.dio_oe !== exp_oe(t_idx)) oe_err++;
               if (t_idx <= 8) t_hdr = {t_hdr[6:0], bus.dio_out};
               if (t_idx == 8) t_rnw = t_hdr[7];
               if (t_idx == 9) t_hpar = bus.dio_out;
               if (t_ack == 3'b001 && !t_rnw && t_idx >= 15 && t_idx <= 46)
                  t_wcap = {bus.dio_out, t_wcap[31:1]};
               if (t_ack == 3'b001 && !t_rnw && t_idx == 47) t_wpar = bus.dio_out;
               if (t_idx == ((t_ack == 3'b001) ? 48 : 15)) t_in_frame = 1'b0;
               else t_idx++;
            end
         end else begin
            bus.dio_in = 1'b0;
            if (t_in_frame && t_present) begin
               if (t_idx >= 11 && t_idx <= 13)
                  bus.dio_in = t_ack[2'(t_idx - 11)];
               else if (t_ack == 3'b001 && t_rnw && t_idx >= 14 && t_idx <= 45)
                  bus.dio_in = t_rdata[5'(t_idx - 14)];
               else if (t_ack == 3'b001 && t_rnw && t_idx == 46)
                  bus.dio_in = (^t_rdata) ^ t_flip;
            end
         end
      end
   end

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (bus.rsp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_rsp status=%0d rdata=%0h", bus.rsp_status, bus.rsp_rdata);
            end else begin
               e = exp_q.pop_front();
               chk("rsp_status", 32'(bus.rsp_status), 32'(e.status));
               chk("rsp_rdata", bus.rsp_rdata, e.rdata);
               chk("latency", 32'(cyc - e.acc), 32'(e.lat));
            end
         end
      end
   end

   task automatic issue(input logic wr, input logic [6:0] addr, input logic [31:0] wd,
                        input bit push, input logic [1:0] st, input logic [31:0] rd,
                        input int lat);
      int n = 0;
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_write = wr;
      bus.req_addr  = addr;
      bus.req_wdata = wd;
      t_attempts    = 0;
      while (bus.req_ready !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (bus.req_ready !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL req_ready_timeout actual=%b expected=1", bus.req_ready);
         bus.req_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      bus.req_write = ~wr;
      bus.req_addr  = ~addr;
      bus.req_wdata = ~wd;
      if (push) exp_q.push_back('{st, rd, lat, cyc});
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      while (exp_q.size() != 0 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout actual=%0d pending expected=0", name, exp_q.size());
         exp_q.delete();
      end
      repeat (2) @(negedge clk);
   endtask

   initial begin : stim
      bus.req_valid = 1'b0;
      bus.req_write = 1'b0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;

      repeat (3) @(negedge clk);
      #1;
      chk("rst_dck", 32'(bus.dck), 32'd0);
      chk("rst_oe", 32'(bus.dio_oe), 32'd1);
      chk("rst_out", 32'(bus.dio_out), 32'd0);
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst_status", 32'(bus.rsp_status), 32'd0);
      chk("rst_rdata", bus.rsp_rdata, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_ready", 32'(bus.req_ready), 32'd1);

      // Write, OK ack
      oe_err = 0;
      t_wait_n = 0;
      issue(1'b1, 7'h05, 32'hDEADBEEF, 1'b1, 2'd0, 32'h0, 196);
      wait_done("wr_ok");
      chk("wr_hdr", 32'(t_hdr), 32'h05);
      chk("wr_hpar", 32'(t_hpar), 32'd0);
      chk("wr_wdata", t_wcap, 32'hDEADBEEF);
      chk("wr_wpar", 32'(t_wpar), 32'd0);
      chk("wr_oe_pattern", 32'(oe_err), 32'd0);

      // Read, OK ack, correct parity
      t_rdata = 32'h12345678;
      t_flip  = 1'b0;
      issue(1'b0, 7'h7F, 32'h0, 1'b1, 2'd0, 32'h12345678, 196);
      wait_done("rd_ok");
      chk("rd_hdr", 32'(t_hdr), 32'hFF);
      chk("rd_hpar", 32'(t_hpar), 32'd0);
      chk("rd_oe_pattern", 32'(oe_err), 32'd0);

      // Reads with flipped parity bit
      t_rdata = 32'h87654321;
      t_flip  = 1'b1;
      issue(1'b0, 7'h7F, 32'h0, 1'b1, 2'd3, 32'h87654321, 196);
      wait_done("rd_perr_a");
      t_rdata = 32'h12345678;
      issue(1'b0, 7'h7F, 32'h0, 1'b1, 2'd3, 32'h12345678, 196);
      wait_done("rd_perr_b");
      t_flip = 1'b0;

      // WAIT on every attempt: 1 + 8 retries of 16 bits each
      t_wait_n = 1000;
      t_starts = 0;
      issue(1'b0, 7'h10, 32'h0, 1'b1, 2'd1, 32'h12345678, 9 * 16 * 2 * DIV);
      wait_done("wait_all");
      chk("wait_starts", 32'(t_starts), 32'd9);
      chk("wait_oe_pattern", 32'(oe_err), 32'd0);

      // WAIT twice, OK on third attempt
      t_wait_n = 2;
      t_starts = 0;
      issue(1'b1, 7'h22, 32'h00000001, 1'b1, 2'd0, 32'h12345678, (2 * 16 + 49) * 2 * DIV);
      wait_done("wait_then_ok");
      chk("wok_starts", 32'(t_starts), 32'd3);
      chk("wok_wdata", t_wcap, 32'h00000001);
      chk("wok_wpar", 32'(t_wpar), 32'd1);
      t_wait_n = 0;

      // Target absent
      t_present = 1'b0;
      issue(1'b0, 7'h01, 32'h0, 1'b1, 2'd2, 32'h12345678, 16 * 2 * DIV);
      wait_done("absent");
      chk("absent_oe_pattern", 32'(oe_err), 32'd0);
      t_present = 1'b1;

      // Reset in the middle of RDATA
      t_rdata = 32'hFFFF0000;
      issue(1'b0, 7'h2A, 32'h0, 1'b0, 2'd0, 32'h0, 0);
      for (int i = 0; i < 500 && !(t_in_frame && t_idx == 20); i++) @(negedge clk);
      if (!(t_in_frame && t_idx == 20)) begin
         checks++;
         errors++;
         $display("FAIL mid_rdata_timeout actual=%0d expected=20", t_idx);
      end
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_dck", 32'(bus.dck), 32'd0);
      chk("mid_rst_oe", 32'(bus.dio_oe), 32'd1);
      chk("mid_rst_out", 32'(bus.dio_out), 32'd0);
      chk("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("mid_rst_rdata", bus.rsp_rdata, 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("mid_rst_ready", 32'(bus.req_ready), 32'd1);
      oe_err = 0;
      issue(1'b1, 7'h33, 32'h0F0F00FF, 1'b1, 2'd0, 32'h0, 196);
      wait_done("post_rst_wr");
      chk("post_rst_hdr", 32'(t_hdr), 32'h33);
      chk("post_rst_wdata", t_wcap, 32'h0F0F00FF);
      chk("post_rst_oe_pattern", 32'(oe_err), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
